// File: rtl/arbitrary_seq_counter.sv
// arbitrary_seq_counter: steps through a rewritable table of codes up/down with wrap,
// recovering from loads of out-of-sequence values by a one-entry-per-cycle table search.
module arbitrary_seq_counter #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             Wr_en,
  input  logic [AW-1:0]    Wr_addr,
  input  logic [WIDTH-1:0] Wr_data,
  input  logic [LW-1:0]    Len,
  output logic [WIDTH-1:0] Q,
  output logic [AW-1:0]    Idx,
  output logic             Busy,
  output logic             Wrap,
  output logic             OutOfSeq
);
  typedef enum logic {RUN, SEARCH} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] tbl_q [DEPTH];
  logic [WIDTH-1:0] q_q, val_q;
  logic [AW-1:0]    idx_q, ptr_q, idx_d, last;
  logic [LW-1:0]    len_eff, idx_ext, ptr_ext;
  logic             oos, at_top, wrap_d, wrap_q, oos_q;
  assign len_eff = (Len == '0) ? LW'(1) : (Len > LW'(DEPTH)) ? LW'(DEPTH) : Len;
  assign idx_ext = LW'(idx_q);
  assign ptr_ext = LW'(ptr_q);
  assign last    = AW'(len_eff - LW'(1));
  assign oos     = idx_ext >= len_eff;
  assign at_top  = idx_ext + LW'(1) >= len_eff;
  // An index stranded beyond a shrunk length recovers without flagging a wrap
  assign idx_d   = Dir ? ((oos || idx_q == '0) ? last : idx_q - AW'(1))
                       : ((oos || at_top) ? '0 : idx_q + AW'(1));
  assign wrap_d  = !oos && (Dir ? idx_q == '0 : at_top);
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state_q <= RUN;
      q_q     <= '0;
      val_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      wrap_q  <= 1'b0;
      oos_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= WIDTH'(i);
    end else begin
      wrap_q <= 1'b0;
      oos_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        if (Wr_en && state_q == RUN && Wr_addr == AW'(i)) tbl_q[i] <= Wr_data;
      if (Load) begin
        val_q   <= LoadVal;
        ptr_q   <= '0;
        state_q <= SEARCH;
      end else if (state_q == RUN) begin
        if (En) begin
          idx_q  <= idx_d;
          q_q    <= tbl_q[idx_d];
          wrap_q <= wrap_d;
          oos_q  <= oos;
        end
      end else if (tbl_q[ptr_q] == val_q) begin
        idx_q   <= ptr_q;
        q_q     <= val_q;
        state_q <= RUN;
      end else if (ptr_ext + LW'(1) >= len_eff) begin
        idx_q   <= '0;
        q_q     <= tbl_q[0];
        oos_q   <= 1'b1;
        state_q <= RUN;
      end else begin
        ptr_q <= ptr_q + AW'(1);
      end
    end
  assign Q        = q_q;
  assign Idx      = idx_q;
  assign Busy     = state_q == SEARCH;
  assign Wrap     = wrap_q;
  assign OutOfSeq = oos_q;
endmodule

// File: tb/tb_arbitrary_seq_counter.sv
// tb_arbitrary_seq_counter: directed scenarios then random traffic against a table/search reference model.
module tb_arbitrary_seq_counter;
  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam int LW = 4;
  logic             Clk = 1'b0;
  logic             Reset, En, Dir, Load, Wr_en;
  logic [WIDTH-1:0] LoadVal, Wr_data, Q;
  logic [AW-1:0]    Wr_addr, Idx;
  logic [LW-1:0]    Len;
  logic             Busy, Wrap, OutOfSeq;
  int vecs = 0;
  int fails = 0;
  int m_tbl [DEPTH];
  int m_idx, m_q, m_cnt, m_res_idx, m_res_q;
  bit m_wrap, m_oos, m_res_oos;
  int tp1_q [6] = '{1, 2, 3, 4, 0, 1};
  int tp1_w [6] = '{0, 0, 0, 0, 1, 0};
  int tp2_t [4] = '{3, 9, 5, 12};
  int tp2_q [6] = '{3, 12, 5, 9, 3, 12};
  int tp2_w [6] = '{0, 1, 0, 0, 0, 1};
  arbitrary_seq_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Dir(Dir), .Load(Load), .LoadVal(LoadVal),
    .Wr_en(Wr_en), .Wr_addr(Wr_addr), .Wr_data(Wr_data), .Len(Len),
    .Q(Q), .Idx(Idx), .Busy(Busy), .Wrap(Wrap), .OutOfSeq(OutOfSeq)
  );
  always #5 Clk = ~Clk;
  function automatic int eff_len();
    return (Len == 0) ? 1 : (int'(Len) > DEPTH) ? DEPTH : int'(Len);
  endfunction
  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = i;
    m_idx = 0; m_q = 0; m_cnt = 0; m_wrap = 0; m_oos = 0;
  endtask
  task automatic start_search(input int L);
    int k = -1;
    for (int i = 0; i < L; i++) if (k < 0 && m_tbl[i] == int'(LoadVal)) k = i;
    if (k >= 0) begin
      m_cnt = k + 1; m_res_idx = k; m_res_q = int'(LoadVal); m_res_oos = 0;
    end else begin
      m_cnt = L; m_res_idx = 0; m_res_q = m_tbl[0]; m_res_oos = 1;
    end
  endtask
  task automatic model_step();
    int L = eff_len();
    int ni;
    m_wrap = 0; m_oos = 0;
    if (Load) begin
      if (m_cnt == 0 && Wr_en) m_tbl[int'(Wr_addr)] = int'(Wr_data);
      start_search(L);
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_idx = m_res_idx; m_q = m_res_q; m_oos = m_res_oos;
      end
    end else begin
      if (En) begin
        if (m_idx >= L) begin
          ni = Dir ? L - 1 : 0;
          m_oos = 1;
        end else begin
          ni = Dir ? (m_idx + L - 1) % L : (m_idx + 1) % L;
          m_wrap = Dir ? (m_idx == 0) : (m_idx == L - 1);
        end
        m_idx = ni;
        m_q = m_tbl[ni];
      end
      if (Wr_en) m_tbl[int'(Wr_addr)] = int'(Wr_data);
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    vecs++;
    assert (obs === 32'(exp)) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, "_q"}, 32'(Q), m_q);
    chk({tag, "_idx"}, 32'(Idx), m_idx);
    chk({tag, "_busy"}, 32'(Busy), int'(m_cnt > 0));
    chk({tag, "_wrap"}, 32'(Wrap), int'(m_wrap));
    chk({tag, "_oos"}, 32'(OutOfSeq), int'(m_oos));
  endtask
  task automatic tick(input string tag);
    @(posedge Clk);
    model_step();
    #1;
    check_all(tag);
  endtask
  initial begin
    Reset = 1'b1; En = 0; Dir = 0; Load = 0; LoadVal = '0;
    Wr_en = 0; Wr_addr = '0; Wr_data = '0; Len = '0;
    model_reset();
    #7;
    check_all("reset");
    #1 Reset = 1'b0;
    Len = 5; En = 1; Dir = 0;
    for (int i = 0; i < 6; i++) begin
      tick("up5");
      chk("up5_q_spec", 32'(Q), tp1_q[i]);
      chk("up5_wrap_spec", 32'(Wrap), tp1_w[i]);
    end
    En = 0; Wr_en = 1;
    for (int i = 0; i < 4; i++) begin
      Wr_addr = AW'(i); Wr_data = WIDTH'(tp2_t[i]);
      tick("wr");
    end
    Wr_en = 0; Len = 4; Dir = 1; En = 1;
    for (int i = 0; i < 6; i++) begin
      tick("dn4");
      chk("dn4_q_spec", 32'(Q), tp2_q[i]);
      chk("dn4_wrap_spec", 32'(Wrap), tp2_w[i]);
    end
    En = 0; Load = 1; LoadVal = 5;
    tick("ld5");
    Load = 0;
    for (int i = 0; i < 3; i++) begin
      tick("ld5_s");
      chk("ld5_busy_spec", 32'(Busy), int'(i < 2));
    end
    chk("ld5_idx_spec", 32'(Idx), 2);
    chk("ld5_q_spec", 32'(Q), 5);
    En = 1; Dir = 0;
    tick("ld5_step");
    chk("ld5_step_q_spec", 32'(Q), 12);
    En = 0; Load = 1; LoadVal = 7;
    tick("ld7");
    Load = 0;
    for (int i = 0; i < 4; i++) tick("ld7_s");
    chk("ld7_q_spec", 32'(Q), 3);
    chk("ld7_idx_spec", 32'(Idx), 0);
    chk("ld7_oos_spec", 32'(OutOfSeq), 1);
    tick("ld7_after");
    chk("ld7_oos_clear_spec", 32'(OutOfSeq), 0);
    Len = 8; En = 1; Dir = 0;
    for (int i = 0; i < 6; i++) tick("to6");
    Len = 4;
    tick("shrink_up");
    chk("shrink_up_idx_spec", 32'(Idx), 0);
    chk("shrink_up_oos_spec", 32'(OutOfSeq), 1);
    chk("shrink_up_wrap_spec", 32'(Wrap), 0);
    Len = 8;
    for (int i = 0; i < 6; i++) tick("to6b");
    Len = 4; Dir = 1;
    tick("shrink_dn");
    chk("shrink_dn_idx_spec", 32'(Idx), 3);
    chk("shrink_dn_oos_spec", 32'(OutOfSeq), 1);
    En = 0; Len = 8; Load = 1; LoadVal = 6;
    tick("ld6");
    Load = 0; Wr_en = 1; Wr_addr = 1; Wr_data = 15;
    tick("ld6_wr");
    #2 Reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    Wr_en = 0;
    #1 Reset = 1'b0;
    En = 1; Dir = 0;
    for (int i = 0; i < 8; i++) begin
      tick("ident");
      chk("ident_q_spec", 32'(Q), (i + 1) % 8);
    end
    for (int n = 0; n < 600; n++) begin
      En = ($urandom_range(0, 3) != 0);
      Dir = 1'($urandom_range(0, 1));
      Load = ($urandom_range(0, 11) == 0);
      LoadVal = $urandom_range(0, 1) ? WIDTH'(m_tbl[$urandom_range(0, DEPTH - 1)])
                                     : WIDTH'($urandom_range(0, 15));
      Wr_en = ($urandom_range(0, 3) == 0);
      Wr_addr = AW'($urandom_range(0, DEPTH - 1));
      Wr_data = WIDTH'($urandom_range(0, 15));
      if (m_cnt == 0 && !Load && $urandom_range(0, 15) == 0) Len = LW'($urandom_range(0, 15));
      tick("rnd");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule

// File: doc/arbitrary_seq_counter.md
Name: arbitrary_seq_counter

Overview:
- Programmable arbitrary-sequence counter: steps through a run-time-loadable table of WIDTH-bit codes, up or down, with wrap.
- Generalises the fixed 4-bit sequence counter and its out-of-sequence remapper. Width, table depth and the recovery code are parameters. The sequence is rewritable. Out-of-sequence values are detected and recovered by a sequential table search instead of fixed gating.
- Sits at the counter/display boundary. Q drives the downstream decoder directly.

Parameters:
- WIDTH, 4, bits per code (Q, LoadVal, Wr_data).
- DEPTH, 8, number of table entries, 2 ≤ DEPTH ≤ 2^WIDTH.
- AW, $clog2(DEPTH), width of the index and table address (derived, not overridden).
- LW, $clog2(DEPTH+1), width of Len (derived).

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- En  in  1  step enable.
- Dir  in  1  0 = up (increasing index), 1 = down.
- Load  in  1  request to jump to LoadVal.
- LoadVal  in  WIDTH  target code for Load.
- Wr_en  in  1  table write strobe.
- Wr_addr  in  AW  table entry to write.
- Wr_data  in  WIDTH  code to store.
- Len  in  LW  active sequence length.
- Q  out  WIDTH  current code (registered).
- Idx  out  AW  current table index (registered).
- Busy  out  1  search in progress.
- Wrap  out  1  one-cycle pulse on sequence wrap.
- OutOfSeq  out  1  one-cycle pulse on recovery.

Behaviour:
- One clock; Reset is asynchronous and active-high. All state is flops cleared by Reset.
- Reset values:
  - table[i] = i mod 2^WIDTH.
  - Idx = 0, Q = 0.
  - Busy = 0, Wrap = 0, OutOfSeq = 0.
  - FSM = RUN.
- Effective length L: Len=0 is treated as 1; Len>DEPTH is treated as DEPTH. L is sampled every cycle.
- FSM states: RUN, SEARCH.
- RUN, priority Load > En:
  - Load=1: latch LoadVal, scan pointer = 0, go to SEARCH, Busy=1 from the next cycle.
  - Else En=1 and Dir=0: Idx' = (Idx+1 ≥ L) ? 0 : Idx+1. Wrap=1 when the result is 0 due to wrap.
  - Else En=1 and Dir=1: Idx' = (Idx==0 || Idx ≥ L) ? L-1 : Idx-1. Wrap=1 when Idx==0.
  - In both step cases Q' = table[Idx'] at the same edge (one-cycle latency from En to Q).
  - Idx ≥ L (Len shrunk) when En is asserted with Dir=0: Idx'=0, Q'=table[0], OutOfSeq=1, Wrap=0.
  - Idx ≥ L when En is asserted with Dir=1: wraps to L-1 with Wrap=0, OutOfSeq=1.
  - En=0: Idx and Q hold, even if Idx ≥ L.
- SEARCH: one table entry compared per cycle, at the scan pointer p.
  - table[p]==latched value: Idx=p, Q=value, go to RUN. Lowest matching index wins on duplicates.
  - No match and p==L-1: Idx=0, Q=table[0], OutOfSeq=1, go to RUN.
  - Otherwise p=p+1.
  - A match at index k leaves Busy high for k+1 cycles. No match leaves Busy high for L cycles.
  - En is ignored in SEARCH.
  - A new Load in SEARCH restarts the search with the new value, p=0.
- Table writes:
  - Accepted in RUN only; Wr_en while Busy=1 is dropped.
  - A write takes effect at the edge. Q is not refreshed by a write to the current Idx; the new code appears on the next step or Load.
  - Write and step in the same cycle: the step reads the old table contents.
- Wrap and OutOfSeq are high for exactly one cycle after the causing edge, otherwise 0.
- Reset mid-SEARCH: immediate return to the reset values; the search is discarded.

Test Plan:
- Reset, Len=5, En=1, Dir=0 for 7 cycles → Q: 0,1,2,3,4,0,1; Wrap high only on the 0 after 4.
- Write table {3,9,5,12}, Len=4, Dir=1, En=1 from Idx 0 → Q: 12,5,9,3,12; Wrap on the first 12.
- From RUN, Load with LoadVal=5 → Busy 3 cycles, then Idx=2, Q=5; the next up step gives Q=12.
- Load with LoadVal=7 (absent), Len=4 → Busy 4 cycles, then Q=3, Idx=0, OutOfSeq pulse 1 cycle.
- Idx=6, Len changed to 4, En=1, Dir=0 → Idx=0, Q=table[0], OutOfSeq=1, Wrap=0.
- Reset asserted asynchronously during cycle 2 of a SEARCH, plus Wr_en during Busy → all outputs at reset values, table at identity, the dropped write absent.
